// File: rtl/ddr_read_scheduler_pkg.sv
// Shared DDR read-scheduler definitions: read FSM state encoding and default sizes.
package ddr_read_scheduler_pkg;

    localparam int RD_ADDR_W_DEF      = 24;
    localparam int RD_DATA_W_DEF      = 16;
    localparam int RD_BURST_BEATS_DEF = 4;
    localparam int RD_TIMEOUT_DEF     = 255;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CMD       = 2'd1,
        WAIT_DATA = 2'd2
    } rd_state_e;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr_read_scheduler_if.sv
// Bus bundle between the read scheduler, its two requesters, the command FSM and the read datapath.
interface ddr_read_scheduler_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic              gnt0, gnt1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              rvalid0, rvalid1;
    logic              rlast0, rlast1;
    logic              rd_cmd_valid;
    logic [ADDR_W-1:0] rd_cmd_addr;
    logic              rd_cmd_ready;
    logic              dp_data_rdy;
    logic [DATA_W-1:0] dp_data;

    modport master (
        input  req0, req1, addr0, addr1, rd_cmd_ready, dp_data_rdy, dp_data,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, rlast0, rlast1,
               rd_cmd_valid, rd_cmd_addr
    );

    modport slave (
        output req0, req1, addr0, addr1, rd_cmd_ready, dp_data_rdy, dp_data,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, rlast0, rlast1,
               rd_cmd_valid, rd_cmd_addr
    );
endinterface

// File: rtl/ddr_rd_rr_arb.sv
// Two-way round-robin arbiter; the last-granted pointer is held by the parent.
module ddr_rd_rr_arb (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_idx,
    output logic gnt_valid
);
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_idx   = 1'b0;
        if (req0 && req1) gnt_idx = ~last_gnt;
        else if (req1)    gnt_idx = 1'b1;
    end
endmodule

// File: rtl/ddr_read_scheduler.sv
// DDR read scheduler: round-robin grant, one read command per grant, burst beat routing.
// Optional idle-beat timeout abort when RD_TIMEOUT_EN is defined.
module ddr_read_scheduler
    import ddr_read_scheduler_pkg::*;
#(
    parameter int ADDR_W      = RD_ADDR_W_DEF,
    parameter int DATA_W      = RD_DATA_W_DEF,
    parameter int BURST_BEATS = RD_BURST_BEATS_DEF
`ifdef RD_TIMEOUT_EN
    , parameter int TIMEOUT   = RD_TIMEOUT_DEF
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_done,
    ddr_read_scheduler_if.master bus,
    output logic                 busy
`ifdef RD_TIMEOUT_EN
    , output logic               timeout_err
`endif
);
    localparam int               CNT_W     = cnt_w(BURST_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

    rd_state_e        state_q, state_d;
    logic             ptr_q;
    logic [CNT_W-1:0] beat_q;
    logic             arb_idx, arb_valid;
    logic             grant, accept, beat, last_beat, expire;

    ddr_rd_rr_arb u_arb (
        .req0      (bus.req0),
        .req1      (bus.req1),
        .last_gnt  (ptr_q),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        accept    = 1'b0;
        beat      = 1'b0;
        last_beat = 1'b0;
        unique case (state_q)
            IDLE: if (init_done && arb_valid) begin
                grant   = 1'b1;
                state_d = CMD;
            end
            CMD: if (bus.rd_cmd_ready) begin
                accept  = 1'b1;
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (bus.dp_data_rdy) begin
                    beat = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        last_beat = 1'b1;
                        state_d   = IDLE;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy             = (state_q != IDLE);
    assign bus.rd_cmd_valid = (state_q == CMD);

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            ptr_q           <= 1'b1;
            beat_q          <= '0;
            bus.rd_cmd_addr <= '0;
            bus.gnt0        <= 1'b0;
            bus.gnt1        <= 1'b0;
            bus.rdata0      <= '0;
            bus.rdata1      <= '0;
            bus.rvalid0     <= 1'b0;
            bus.rvalid1     <= 1'b0;
            bus.rlast0      <= 1'b0;
            bus.rlast1      <= 1'b0;
        end else begin
            state_q  <= state_d;
            bus.gnt0 <= grant && !arb_idx;
            bus.gnt1 <= grant &&  arb_idx;
            if (grant) begin
                ptr_q           <= arb_idx;
                bus.rd_cmd_addr <= arb_idx ? bus.addr1 : bus.addr0;
            end
            if (accept || last_beat) beat_q <= '0;
            else if (beat)           beat_q <= beat_q + 1'b1;
            // ptr_q names the port that owns the burst in flight.
            bus.rvalid0 <= (beat || expire) && !ptr_q;
            bus.rvalid1 <= (beat || expire) &&  ptr_q;
            bus.rlast0  <= (last_beat || expire) && !ptr_q;
            bus.rlast1  <= (last_beat || expire) &&  ptr_q;
            if ((beat || expire) && !ptr_q) bus.rdata0 <= beat ? bus.dp_data : '0;
            if ((beat || expire) &&  ptr_q) bus.rdata1 <= beat ? bus.dp_data : '0;
        end
    end

`ifdef RD_TIMEOUT_EN
    logic [7:0] idle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= expire;
            if (accept || beat)           idle_q <= '0;
            else if (state_q == WAIT_DATA) idle_q <= idle_q + 8'd1;
        end
    end

    assign expire = (state_q == WAIT_DATA) && !bus.dp_data_rdy && (idle_q == 8'(TIMEOUT - 1));
`else
    assign expire = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_read_scheduler.sv
// Self-checking bench for ddr_read_scheduler: transaction-level model plus directed scenarios.
// Exercises the idle-beat timeout as well when RD_TIMEOUT_EN is defined.
module tb_ddr_read_scheduler;
    localparam int BB  = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_done = 1'b0;
    logic busy;
`ifdef RD_TIMEOUT_EN
    logic timeout_err;
`endif

    ddr_read_scheduler_if #(.ADDR_W(24), .DATA_W(16)) bus ();

    ddr_read_scheduler #(
        .ADDR_W(24), .DATA_W(16), .BURST_BEATS(BB)
`ifdef RD_TIMEOUT_EN
        , .TIMEOUT(TMO)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .bus       (bus),
        .busy      (busy)
`ifdef RD_TIMEOUT_EN
        , .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Phase is implied by m_cmd (command outstanding) and m_left (beats still owed).
    bit          model_ok = 1'b0;
    bit          m_cmd;
    int          m_left, m_idle;
    bit          m_owner, m_last;
    logic [1:0]  e_gnt, e_rvalid, e_rlast;
    logic [15:0] e_rdata [2];
    logic [23:0] e_addr;
    logic        e_to;

    always @(posedge clk) begin
        if (rst) begin
            m_cmd = 0; m_left = 0; m_idle = 0; m_owner = 0; m_last = 1;
            e_gnt = '0; e_rvalid = '0; e_rlast = '0; e_addr = '0; e_to = 0;
            e_rdata[0] = '0; e_rdata[1] = '0;
            model_ok = 1'b1;
        end else begin
            e_gnt = '0; e_rvalid = '0; e_rlast = '0; e_to = 0;
            if (m_cmd) begin
                if (bus.rd_cmd_ready) begin
                    m_cmd = 0; m_left = BB; m_idle = 0;
                end
            end else if (m_left > 0) begin
                if (bus.dp_data_rdy) begin
                    e_rvalid[m_owner] = 1'b1;
                    e_rdata[m_owner]  = bus.dp_data;
                    m_left--; m_idle = 0;
                    if (m_left == 0) e_rlast[m_owner] = 1'b1;
                end
`ifdef RD_TIMEOUT_EN
                else begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        e_to = 1; e_rvalid[m_owner] = 1'b1; e_rlast[m_owner] = 1'b1;
                        e_rdata[m_owner] = '0; m_left = 0;
                    end
                end
`endif
            end else if (init_done && (bus.req0 || bus.req1)) begin
                m_owner = (bus.req0 && bus.req1) ? !m_last : bus.req1;
                m_last  = m_owner;
                e_gnt[m_owner] = 1'b1;
                e_addr = m_owner ? bus.addr1 : bus.addr0;
                m_cmd  = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("gnt",       {bus.gnt1, bus.gnt0},       e_gnt);
            check("rvalid",    {bus.rvalid1, bus.rvalid0}, e_rvalid);
            check("rlast",     {bus.rlast1, bus.rlast0},   e_rlast);
            check("rdata0",    bus.rdata0,                 e_rdata[0]);
            check("rdata1",    bus.rdata1,                 e_rdata[1]);
            check("cmd_valid", bus.rd_cmd_valid,           m_cmd);
            check("cmd_addr",  bus.rd_cmd_addr,            e_addr);
            check("busy",      busy,                       m_cmd || (m_left > 0));
`ifdef RD_TIMEOUT_EN
            check("timeout_err", timeout_err, e_to);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int idx, output int cycles);
        idx = -1;
        cycles = 0;
        while (idx < 0 && cycles < 50) begin
            tick();
            cycles++;
            if (bus.gnt0)      idx = 0;
            else if (bus.gnt1) idx = 1;
        end
        check("gnt_arrived", idx >= 0, 1);
    endtask

    task automatic request(input int port, input logic [23:0] addr);
        int idx, cyc;
        if (port == 0) begin bus.addr0 = addr; bus.req0 = 1'b1; end
        else           begin bus.addr1 = addr; bus.req1 = 1'b1; end
        wait_gnt(idx, cyc);
        check("gnt_port", idx, port);
        check("gnt_addr", bus.rd_cmd_addr, addr);
        if (port == 0) bus.req0 = 1'b0;
        else           bus.req1 = 1'b0;
    endtask

    // Called in the grant cycle; holds ready low for 'delay' cycles, then accepts.
    task automatic cmd_accept(input int delay);
        int seen = 0;
        logic [23:0] a = bus.rd_cmd_addr;
        for (int i = 0; i < delay; i++) begin
            if (bus.rd_cmd_valid && bus.rd_cmd_addr == a) seen++;
            tick();
        end
        if (bus.rd_cmd_valid && bus.rd_cmd_addr == a) seen++;
        bus.rd_cmd_ready = 1'b1;
        tick();
        bus.rd_cmd_ready = 1'b0;
        check("cmd_valid_cycles", seen, delay + 1);
        check("cmd_valid_drop", bus.rd_cmd_valid, 0);
    endtask

    task automatic send_beats(input int port, input int n, input logic [15:0] base, input int gap[4]);
        for (int i = 0; i < n; i++) begin
            repeat (gap[i]) tick();
            bus.dp_data_rdy = 1'b1;
            bus.dp_data     = base + 16'(i);
            tick();
            bus.dp_data_rdy = 1'b0;
            check("beat_valid", port ? bus.rvalid1 : bus.rvalid0, 1);
            check("beat_data",  port ? bus.rdata1  : bus.rdata0,  base + 16'(i));
            check("beat_last",  port ? bus.rlast1  : bus.rlast0,  i == BB - 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int idx, cyc, cnt;
        bus.req0 = 0; bus.req1 = 0; bus.addr0 = '0; bus.addr1 = '0;
        bus.rd_cmd_ready = 0; bus.dp_data_rdy = 0; bus.dp_data = '0;
        tick();
        check("reset_busy", busy, 0);
        check("reset_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
        rst = 1'b0;

        // init_done low: requests ignored
        bus.req0 = 1'b1; bus.addr0 = 24'h123456;
        cnt = 0;
        repeat (10) begin
            tick();
            if (bus.gnt0 || busy) cnt++;
        end
        check("no_gnt_before_init", cnt, 0);
        init_done = 1'b1;
        tick();
        check("first_gnt0", bus.gnt0, 1);
        check("first_addr", bus.rd_cmd_addr, 24'h123456);
        bus.req0 = 1'b0;
        cmd_accept(0);
        send_beats(0, 4, 16'h5000, '{0, 0, 0, 0});
        check("idle_after_burst", busy, 0);

        // both requesting continuously: grants alternate 0,1,0,1 after reset
        do_reset();
        bus.addr0 = 24'h000100; bus.addr1 = 24'h000200;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(idx, cyc);
            check("alt_idx", idx, k % 2);
            check("alt_addr", bus.rd_cmd_addr, (k % 2) ? 24'h000200 : 24'h000100);
            if (k > 0) check("dead_cycle", cyc, 1);
            cmd_accept(0);
            send_beats(k % 2, 4, 16'h0B00 + 16'(k * 16), '{0, 0, 0, 0});
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();

        // slow command acceptance and gapped beats on port 1
        request(1, 24'h0ABCDE);
        cmd_accept(5);
        send_beats(1, 4, 16'hA001, '{0, 0, 2, 0});
        check("busy_low_on_rlast", busy, 0);
        check("port0_quiet", bus.rvalid0, 0);
        tick();

        // reset in the middle of a burst
        request(0, 24'h0C0FFE);
        cmd_accept(1);
        send_beats(0, 2, 16'hBEE0, '{0, 0, 0, 0});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_outputs",
              {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rlast0, bus.rlast1, bus.rd_cmd_valid, busy},
              8'h00);
        check("rst_addr", bus.rd_cmd_addr, 24'h0);
        check("rst_rdata0", bus.rdata0, 16'h0);

        // stray datapath strobe while idle produces nothing
        bus.dp_data_rdy = 1'b1; bus.dp_data = 16'hDEAD;
        tick();
        bus.dp_data_rdy = 1'b0;
        check("stray_beat", {bus.rvalid1, bus.rvalid0}, 2'b00);

        request(0, 24'h0000AA);
        cmd_accept(2);
        send_beats(0, 4, 16'h3300, '{1, 0, 0, 3});
        tick();

`ifdef RD_TIMEOUT_EN
        request(1, 24'h00F00D);
        cmd_accept(0);
        send_beats(1, 1, 16'h7777, '{0, 0, 0, 0});
        cnt = 0;
        repeat (TMO - 1) begin
            tick();
            if (timeout_err) cnt++;
        end
        check("no_early_timeout", cnt, 0);
        tick();
        check("timeout_pulse", timeout_err, 1);
        check("timeout_beat", {bus.rvalid1, bus.rlast1}, 2'b11);
        check("timeout_rdata", bus.rdata1, 16'h0000);
        check("timeout_idle", busy, 0);
        tick();
        check("timeout_one_cycle", timeout_err, 0);
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
